joy_answer_frontend: RTL and testbench

Player-input front end for the two-player quiz game. Samples both active-low 4-way joysticks, synchronises and debounces them, and turns each clean press into a one-hot-to-code answer (1..4). It arbitrates the first press after a question is armed and offers it to the answer checker over a valid/ready handshake, with the winning player and a response-time stamp. It is the responder side to the question sequencer: the sequencer arms a question, and this block returns exactly one answer per arming.

---
 rtl/joy_answer_frontend.sv | 180 ++++++++++++++++++
 tb/tb_joy_answer_frontend.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_answer_frontend.sv
// joy_answer_frontend: two-player joystick front end for the quiz game.
// Each active-low 4-way stick is synchronised, debounced and decoded into an
// answer code 1..4. The first press after a question is armed is offered to
// the answer checker over valid/ready, together with the player and a
// saturating response-time stamp.
// Optional feature macro: JOY_TIE_RR_EN (round-robin resolution of ties;
// when undefined the left player always wins a tie).
module joy_answer_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RT_W            = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      joy_in_l,
  input  logic [3:0]      joy_in_r,
  input  logic            q_valid,
  output logic            ans_valid,
  input  logic            ans_ready,
  output logic            ans_player,
  output logic [2:0]      ans_code,
  output logic [RT_W-1:0] ans_time,
  output logic            armed
);

  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0]  RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_q_prev;
  logic [RT_W-1:0]  r_time;

  logic [3:0]       w_joy      [2];
  logic [3:0]       r_sync1    [2];
  logic [3:0]       r_sync2    [2];
  logic [3:0]       r_cand     [2];
  logic [3:0]       r_deb      [2];
  logic [3:0]       r_deb_prev [2];
  logic [CNT_W-1:0] r_cnt      [2];
  logic [CNT_W-1:0] w_cnt_next [2];
  logic [2:0]       w_code     [2];
  logic [1:0]       w_evt;
  logic             w_q_rise;
  logic             w_win;

  // Exactly one low bit gives its answer code; released/invalid give 0.
  function automatic logic [2:0] f_decode(input logic [3:0] s);
    case (s)
      4'b1110: f_decode = 3'd1;
      4'b1101: f_decode = 3'd2;
      4'b1011: f_decode = 3'd3;
      4'b0111: f_decode = 3'd4;
      default: f_decode = 3'd0;
    endcase
  endfunction

  assign w_joy[0] = joy_in_l;
  assign w_joy[1] = joy_in_r;
  assign w_q_rise = q_valid & ~r_q_prev;

  // Debounce run length (a new value counts as its own first sample), decode, press events.
  always_comb begin
    w_evt = 2'b00;
    for (int p = 0; p < 2; p++) begin
      w_cnt_next[p] = r_cnt[p];
      w_code[p]     = f_decode(r_deb[p]);
      if (r_sync2[p] != r_cand[p]) begin
        w_cnt_next[p] = CNT_W'(1);
      end else if (r_cnt[p] != CNT_W'(DEBOUNCE_CYCLES)) begin
        w_cnt_next[p] = r_cnt[p] + CNT_W'(1);
      end
      w_evt[p] = (r_deb_prev[p] == RELEASED) && (w_code[p] != 3'd0);
    end
  end

  // Synchronisers, debouncers and previous debounced state for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        r_sync1[p]    <= RELEASED;
        r_sync2[p]    <= RELEASED;
        r_cand[p]     <= RELEASED;
        r_deb[p]      <= RELEASED;
        r_deb_prev[p] <= RELEASED;
        r_cnt[p]      <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_sync1[p]    <= w_joy[p];
        r_sync2[p]    <= r_sync1[p];
        r_cand[p]     <= r_sync2[p];
        r_cnt[p]      <= w_cnt_next[p];
        r_deb_prev[p] <= r_deb[p];
        if (w_cnt_next[p] == CNT_W'(DEBOUNCE_CYCLES)) begin
          r_deb[p] <= r_sync2[p];
        end
      end
    end
  end

`ifdef JOY_TIE_RR_EN
  logic r_tie_ptr;
  logic w_tie;

  assign w_tie = &w_evt;
  assign w_win = w_tie ? r_tie_ptr : w_evt[1];

  // Tie pointer: the next tie goes to whoever lost the last arbitrated tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tie_ptr <= 1'b0;
    end else if ((r_state == S_ARMED) && q_valid && w_tie) begin
      r_tie_ptr <= ~r_tie_ptr;
    end
  end
`else
  // Left wins whenever it has an event, including ties.
  assign w_win = ~w_evt[0];
`endif

  // Arm / wait-for-press / offer sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_q_prev   <= 1'b0;
      r_time     <= '0;
      armed      <= 1'b0;
      ans_valid  <= 1'b0;
      ans_player <= 1'b0;
      ans_code   <= 3'd0;
      ans_time   <= '0;
    end else begin
      r_q_prev <= q_valid;
      case (r_state)
        S_IDLE: begin
          if (w_q_rise) begin
            r_state <= S_ARMED;
            armed   <= 1'b1;
            r_time  <= '0;
          end
        end
        S_ARMED: begin
          if (r_time != {RT_W{1'b1}}) begin
            r_time <= r_time + RT_W'(1);
          end
          if (!q_valid) begin
            r_state <= S_IDLE;
            armed   <= 1'b0;
          end else if (|w_evt) begin
            r_state    <= S_OFFER;
            armed      <= 1'b0;
            ans_valid  <= 1'b1;
            ans_player <= w_win;
            ans_code   <= w_win ? w_code[1] : w_code[0];
            ans_time   <= r_time;
          end
        end
        S_OFFER: begin
          if (ans_ready) begin
            r_state    <= S_IDLE;
            ans_valid  <= 1'b0;
            ans_player <= 1'b0;
            ans_code   <= 3'd0;
            ans_time   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          armed   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joy_answer_frontend.sv
// Self-checking bench for joy_answer_frontend: directed scenarios followed by
// randomized stick/question/ready traffic, all checked every cycle against a
// window-based behavioural model of the front end.
`timescale 1ns/1ps
module tb_joy_answer_frontend;

  localparam int unsigned D    = 4;
  localparam int unsigned RTW  = 4;
  localparam int          TMAX = (1 << RTW) - 1;
  localparam int          HL   = D + 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     joy_l, joy_r;
  logic           q_valid, ans_ready;
  logic           ans_valid, ans_player, armed;
  logic [2:0]     ans_code;
  logic [RTW-1:0] ans_time;

  joy_answer_frontend #(.DEBOUNCE_CYCLES(D), .RT_W(RTW)) dut (
    .clk(clk), .rst_n(rst_n), .joy_in_l(joy_l), .joy_in_r(joy_r),
    .q_valid(q_valid), .ans_valid(ans_valid), .ans_ready(ans_ready),
    .ans_player(ans_player), .ans_code(ans_code), .ans_time(ans_time),
    .armed(armed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per player, newest at index 0. The debouncer sees the raw
  // value from two edges earlier; a state is accepted once the D most recent
  // of those are identical.
  logic [3:0] m_hist [2][HL];
  logic [3:0] m_deb  [2];
  bit         m_evt  [2];
  int         m_ecode[2];
  int         m_st;      // 0 waiting for question, 1 armed, 2 offering
  int         m_t;
  bit         m_qprev;
`ifdef JOY_TIE_RR_EN
  bit         m_ptr;
`endif
  int         e_player, e_code, e_time;

  function automatic int code_of(input logic [3:0] s);
    int zeros, pos;
    zeros = 0;
    pos   = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) begin zeros++; pos = i + 1; end
    return (zeros == 1) ? pos : 0;
  endfunction

  task automatic model_step();
    logic [3:0] raw [2];
    logic [3:0] nd;
    bit         same;
    int         w;
    raw[0] = joy_l;
    raw[1] = joy_r;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < HL; i++) m_hist[p][i] = 4'hF;
        m_deb[p]   = 4'hF;
        m_evt[p]   = 1'b0;
        m_ecode[p] = 0;
      end
      m_st    = 0;
      m_t     = 0;
      m_qprev = 1'b0;
`ifdef JOY_TIE_RR_EN
      m_ptr   = 1'b0;
`endif
      return;
    end
    case (m_st)
      0: if (q_valid && !m_qprev) begin m_st = 1; m_t = 0; end
      1: begin
        if (!q_valid) m_st = 0;
        else if (m_evt[0] || m_evt[1]) begin
          if (m_evt[0] && m_evt[1]) begin
`ifdef JOY_TIE_RR_EN
            w = int'(m_ptr);
            m_ptr = !m_ptr;
`else
            w = 0;
`endif
          end else begin
            w = m_evt[1] ? 1 : 0;
          end
          e_player = w;
          e_code   = m_ecode[w];
          e_time   = m_t;
          m_st     = 2;
        end
        if (m_t < TMAX) m_t++;
      end
      default: if (ans_ready) m_st = 0;
    endcase
    m_qprev = q_valid;
    for (int p = 0; p < 2; p++) begin
      for (int i = HL - 1; i > 0; i--) m_hist[p][i] = m_hist[p][i-1];
      m_hist[p][0] = raw[p];
      nd = m_deb[p];
      same = 1'b1;
      for (int i = 3; i < HL; i++) if (m_hist[p][i] != m_hist[p][2]) same = 1'b0;
      if (same) nd = m_hist[p][2];
      m_evt[p]   = (m_deb[p] == 4'hF) && (code_of(nd) != 0);
      m_ecode[p] = code_of(nd);
      m_deb[p]   = nd;
    end
  endtask

  task automatic check_outputs();
    chk("armed",      int'(armed),      (m_st == 1) ? 1 : 0);
    chk("ans_valid",  int'(ans_valid),  (m_st == 2) ? 1 : 0);
    chk("ans_player", int'(ans_player), (m_st == 2) ? e_player : 0);
    chk("ans_code",   int'(ans_code),   (m_st == 2) ? e_code : 0);
    chk("ans_time",   int'(ans_time),   (m_st == 2) ? e_time : 0);
  endtask

  // ---------------- stimulus helpers ----------------
  int n_xfer = 0;
  int x_player, x_code, x_time;

  task automatic tick();
    if (ans_valid && ans_ready && rst_n) begin
      n_xfer++;
      x_player = int'(ans_player);
      x_code   = int'(ans_code);
      x_time   = int'(ans_time);
    end
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_xfer(input int budget, input string tag);
    int start;
    start = n_xfer;
    for (int i = 0; i < budget && n_xfer == start; i++) tick();
    chk(tag, n_xfer - start, 1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget && !ans_valid; i++) tick();
    chk(tag, int'(ans_valid), 1);
  endtask

  task automatic settle();
    joy_l = 4'hF; joy_r = 4'hF; q_valid = 1'b0;
    repeat (D + 4) tick();
  endtask

  int edges, start, s_code, s_player, s_time;
  int exp_w [3];
  logic [3:0] base_l, base_r;

  initial begin
    rst_n = 1'b0; joy_l = 4'hF; joy_r = 4'hF; q_valid = 1'b0; ans_ready = 1'b0;
    x_player = 0; x_code = 0; x_time = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", int'(ans_valid), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_code",  int'(ans_code), 0);

    // Arm and press left 1011: offer after D+3 edges, then accept.
    q_valid = 1'b1; joy_l = 4'b1011;
    edges = 0;
    while (!ans_valid && edges < 20) begin tick(); edges++; end
    chk("lat_edges", edges, D + 3);
    chk("s1_player", int'(ans_player), 0);
    chk("s1_code",   int'(ans_code), 3);
    ans_ready = 1'b1;
    tick();
    chk("s1_drop",  int'(ans_valid), 0);
    chk("s1_idle",  int'(armed), 0);
    ans_ready = 1'b0;
    settle();

    // Bouncing right stick then clean hold: exactly one offer.
    q_valid = 1'b1; ans_ready = 1'b1;
    tick();
    start = n_xfer;
    for (int i = 0; i < 20; i++) begin
      joy_r = ((i / 2) % 2 == 1) ? 4'hF : 4'b1110;
      tick();
    end
    joy_r = 4'b1110;
    repeat (D + 6) tick();
    chk("bnc_count",  n_xfer - start, 1);
    chk("bnc_player", x_player, 1);
    chk("bnc_code",   x_code, 1);
    q_valid = 1'b0; tick(); tick();
    q_valid = 1'b1;
    repeat (20) tick();
    chk("bnc_norepeat", n_xfer - start, 1);
    settle();

    // Simultaneous presses, three rounds.
`ifdef JOY_TIE_RR_EN
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0;
`else
    exp_w[0] = 0; exp_w[1] = 0; exp_w[2] = 0;
`endif
    for (int r = 0; r < 3; r++) begin
      q_valid = 1'b1;
      tick();
      joy_l = 4'b0111; joy_r = 4'b0111;
      wait_xfer(D + 10, "tie_xfer");
      chk("tie_win",  x_player, exp_w[r]);
      chk("tie_code", x_code, 4);
      settle();
    end

    // Pending offer held with ready low while q falls and the other stick presses.
    ans_ready = 1'b0; q_valid = 1'b1;
    tick();
    joy_l = 4'b1101;
    wait_valid(D + 10, "hold_offer");
    s_code = int'(ans_code); s_player = int'(ans_player); s_time = int'(ans_time);
    chk("hold_code0", s_code, 2);
    start = n_xfer;
    q_valid = 1'b0; joy_r = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid",  int'(ans_valid), 1);
      chk("hold_code",   int'(ans_code), s_code);
      chk("hold_player", int'(ans_player), s_player);
      chk("hold_time",   int'(ans_time), s_time);
    end
    ans_ready = 1'b1;
    repeat (4) tick();
    chk("hold_single", n_xfer - start, 1);
    settle();

    // Invalid two-low pattern while armed: no offer.
    start = n_xfer;
    q_valid = 1'b1;
    tick();
    joy_l = 4'b1010;
    repeat (D + 10) tick();
    chk("inv_none",  n_xfer - start, 0);
    chk("inv_armed", int'(armed), 1);
    settle();

    // Press while idle, then arm: nothing until release and a fresh press.
    joy_l = 4'b0111;
    repeat (D + 6) tick();
    q_valid = 1'b1;
    repeat (D + 6) tick();
    chk("idle_press_none", n_xfer - start, 0);
    joy_l = 4'hF;
    repeat (D + 4) tick();
    joy_l = 4'b1110;
    wait_xfer(D + 10, "repress_xfer");
    chk("repress_code", x_code, 1);
    settle();

    // Long wait before the press: response time saturates; reset drops offer.
    ans_ready = 1'b0; q_valid = 1'b1;
    repeat (20) tick();
    joy_l = 4'b1110;
    wait_valid(D + 10, "sat_offer");
    chk("sat_time", int'(ans_time), TMAX);
    rst_n = 1'b0; joy_l = 4'hF; q_valid = 1'b1; joy_r = 4'b1011;
    tick();
    chk("rst_drop", int'(ans_valid), 0);
    tick();
    // Key held through reset with q already high: arms and offers once debounced.
    rst_n = 1'b1; ans_ready = 1'b1;
    wait_xfer(D + 12, "held_rst_xfer");
    chk("held_rst_player", x_player, 1);
    chk("held_rst_code",   x_code, 3);
    settle();

    // Randomized traffic.
    base_l = 4'hF; base_r = 4'hF;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: base_l = 4'hF;
          5, 6, 7:       base_l = 4'(~(4'b0001 << $urandom_range(0, 3)));
          default:       base_l = 4'($urandom());
        endcase
      end
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: base_r = 4'hF;
          5, 6, 7:       base_r = 4'(~(4'b0001 << $urandom_range(0, 3)));
          default:       base_r = 4'($urandom());
        endcase
      end
      if ($urandom_range(0, 49) == 0) begin
        base_l = 4'(~(4'b0001 << $urandom_range(0, 3)));
        base_r = base_l;
      end
      joy_l = ($urandom_range(0, 24) == 0) ? ~base_l : base_l;
      joy_r = ($urandom_range(0, 24) == 0) ? ~base_r : base_r;
      if ($urandom_range(0, 29) == 0) q_valid = ~q_valid;
      ans_ready = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
